addr_cal: RTL and testbench
===========================

ADDR_CAL -- requirements
Module: addr_cal

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 pattern_info  input  80  sprite geometry, packed as follows:
- [79:64] append: base address in sprite memory.
- [63:48] res_h: stored width.
- [47:32] res_v: stored height.
- [31:16] act_h: displayed width.
- [15:0] act_v: displayed height.
REQ-005 sprite_info  input  32  sprite placement, packed as follows:
- [31] visible.
- [30] horizontal flip.
- [29:20] x: left edge.
- [19:10] y: top edge.
- [9:0] reserved, ignored.
REQ-006 hcount  input  10  current pixel column, unsigned.
REQ-007 vcount  input  10  current pixel row, unsigned.
REQ-008 addr_output  output  16  sprite-memory address of the current pixel.
REQ-009 valid  output  1  high when the current pixel lies inside the visible sprite.

Function
REQ-010 Both outputs SHALL be registered, with exactly one clk cycle of latency from hcount, vcount, pattern_info and sprite_info.
REQ-011 dx = hcount - x and dy = vcount - y SHALL be computed with at least 11-bit signed or extended arithmetic; x + act_h and y + act_v SHALL NOT wrap.
REQ-012 The pixel is inside the sprite iff x <= hcount < x + act_h and y <= vcount < y + act_v (right and bottom edges exclusive).
REQ-013 valid SHALL be registered as: visible AND inside AND res_h != 0 AND res_v != 0.
REQ-014 Horizontal scale kh SHALL be the k in {0,1,2,3} with act_h == res_h << k; vertical scale kv likewise from act_v and res_v.
REQ-015 If no k matches, kh = 0 and pixels with dx >= res_h are not valid; kv is handled the same way with dy and res_v.
REQ-016 Source coordinates SHALL be col = dx >> kh and row = dy >> kv.
REQ-017 When flip = 1, col SHALL be replaced by res_h - 1 - col; flip never affects row.
REQ-018 addr_output SHALL be append + row*res_h + col, truncated modulo 2^16.
REQ-019 When valid is 0, addr_output SHALL be 0.
REQ-020 The block SHALL be purely a function of its current inputs: no frame state, no caching, and input changes take effect on the next clk edge.
REQ-021 When hcount equals x exactly, col SHALL be 0, or res_h - 1 if flipped; the same rule applies to vcount at y for row.

Reset
REQ-022 While reset_n = 0, addr_output = 0 and valid = 0, asynchronously.
REQ-023 Outputs SHALL resume on the first rising clk edge after reset_n deasserts.
REQ-024 Asserting reset_n mid-frame SHALL immediately force both outputs to 0, with no other side effects.

Verification
REQ-025 Base case: append=0, res/act 64x64, x=100, y=50, visible=1, flip=0, hcount=110, vcount=60 -> next cycle valid=1, addr_output=650.
REQ-026 Flip: the REQ-025 setup with flip=1 -> addr_output=693.
REQ-027 Edges, using the REQ-025 setup:
- hcount=164 -> valid=0, addr_output=0.
- hcount=163, vcount=113 -> valid=1, addr_output=4095.
- hcount=99 -> valid=0.
REQ-028 Visibility and append: the REQ-025 setup with visible=0 -> valid=0; with visible=1 and append=0x0800 -> addr_output=0x0A8A.
REQ-029 Scaling: res 64x64, act 128x128, x=0, y=0, hcount=21, vcount=9 -> col=10, row=4, addr_output=266.
REQ-030 Unmatched scale: res 64, act 100, hcount=70 with x=0 -> valid=0.
REQ-031 Reset: drive reset_n low while valid=1 -> outputs become 0 before the next clk edge; release reset_n -> correct values one cycle later.

Source files
------------

// File: rtl/addr_cal_if.sv
// Sprite address calculator bus: geometry, placement and raster position in,
// registered sprite-memory address and valid flag out.
interface addr_cal_if;
    logic [79:0] pattern_info;
    logic [31:0] sprite_info;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [15:0] addr_output;
    logic        valid;

    modport master (
        output pattern_info,
        output sprite_info,
        output hcount,
        output vcount,
        input  addr_output,
        input  valid
    );

    modport slave (
        input  pattern_info,
        input  sprite_info,
        input  hcount,
        input  vcount,
        output addr_output,
        output valid
    );
endinterface

// File: rtl/addr_cal.sv
// Maps the current raster pixel onto a sprite-memory address, with
// power-of-two upscaling and horizontal flip; one cycle of latency.
module addr_cal (
    input  logic    clk,
    input  logic    reset_n,
    addr_cal_if.slave bus
);

    logic [15:0] w_append;
    logic [15:0] w_res_h;
    logic [15:0] w_res_v;
    logic [15:0] w_act_h;
    logic [15:0] w_act_v;
    logic        w_visible;
    logic        w_flip;
    logic [9:0]  w_x;
    logic [9:0]  w_y;

    assign w_append  = bus.pattern_info[79:64];
    assign w_res_h   = bus.pattern_info[63:48];
    assign w_res_v   = bus.pattern_info[47:32];
    assign w_act_h   = bus.pattern_info[31:16];
    assign w_act_v   = bus.pattern_info[15:0];
    assign w_visible = bus.sprite_info[31];
    assign w_flip    = bus.sprite_info[30];
    assign w_x       = bus.sprite_info[29:20];
    assign w_y       = bus.sprite_info[19:10];

    // {match, k}: smallest k in 0..3 with act == res << k
    function automatic logic [2:0] scale_of(
        input logic [15:0] act,
        input logic [15:0] res
    );
        logic [2:0] r;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if ({3'b000, act} == ({3'b000, res} << k))
                r = {1'b1, k[1:0]};
        end
        return r;
    endfunction

    logic [2:0]  w_sc_h;
    logic [2:0]  w_sc_v;
    logic [16:0] w_x_end;
    logic [16:0] w_y_end;
    logic        w_in_h;
    logic        w_in_v;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic        w_ok_h;
    logic        w_ok_v;
    logic [15:0] w_col;
    logic [15:0] w_col_f;
    logic [15:0] w_row;
    logic [31:0] w_prod;
    logic [15:0] w_addr;
    logic        w_valid;

    assign w_sc_h  = scale_of(w_act_h, w_res_h);
    assign w_sc_v  = scale_of(w_act_v, w_res_v);

    // 17-bit right/bottom edges so x + act never wraps
    assign w_x_end = {7'd0, w_x} + {1'b0, w_act_h};
    assign w_y_end = {7'd0, w_y} + {1'b0, w_act_v};

    assign w_in_h  = (bus.hcount >= w_x) &&
                     ({7'd0, bus.hcount} < w_x_end);
    assign w_in_v  = (bus.vcount >= w_y) &&
                     ({7'd0, bus.vcount} < w_y_end);

    assign w_dx    = bus.hcount - w_x;
    assign w_dy    = bus.vcount - w_y;

    // Unmatched scale falls back to 1:1 and clips at the stored size
    assign w_ok_h  = w_in_h &&
                     (w_sc_h[2] || ({6'd0, w_dx} < w_res_h));
    assign w_ok_v  = w_in_v &&
                     (w_sc_v[2] || ({6'd0, w_dy} < w_res_v));

    assign w_col   = {6'd0, w_dx} >> w_sc_h[1:0];
    assign w_row   = {6'd0, w_dy} >> w_sc_v[1:0];
    assign w_col_f = w_flip ? (w_res_h - 16'd1 - w_col) : w_col;

    assign w_prod  = w_row * w_res_h;
    assign w_addr  = w_append + w_prod[15:0] + w_col_f;

    assign w_valid = w_visible && w_ok_h && w_ok_v &&
                     (w_res_h != 16'd0) && (w_res_v != 16'd0);

    logic w_unused;
    assign w_unused = ^{bus.sprite_info[9:0], w_prod[31:16]};

    logic [15:0] r_addr;
    logic        r_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= 16'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_valid;
            r_addr  <= w_valid ? w_addr : 16'd0;
        end
    end

    assign bus.addr_output = r_addr;
    assign bus.valid       = r_valid;

endmodule

// File: tb/tb_addr_cal.sv
// Self-checking bench for addr_cal: directed cases, reset behaviour and
// randomized traffic against an integer reference model.
module tb_addr_cal;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    addr_cal_if bus ();

    addr_cal dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] pat(
        input int ap, input int rh, input int rv,
        input int ah, input int av
    );
        logic [15:0] a, b, c, d, e;
        a = ap[15:0]; b = rh[15:0]; c = rv[15:0];
        d = ah[15:0]; e = av[15:0];
        return {a, b, c, d, e};
    endfunction

    function automatic logic [31:0] spr(
        input bit vis, input bit fl, input int x, input int y
    );
        logic [9:0] xx, yy;
        xx = x[9:0]; yy = y[9:0];
        return {vis, fl, xx, yy, 10'd0};
    endfunction

    // Reference: {valid, addr} straight from the geometric rules
    function automatic logic [16:0] model(
        input logic [79:0] p, input logic [31:0] s,
        input logic [9:0] h, input logic [9:0] v
    );
        int ap, rh, rv, ah, av, x, y, dx, dy;
        int kh, kv, col, row, addr;
        bit vis, fl, ok;
        ap = int'(p[79:64]); rh = int'(p[63:48]);
        rv = int'(p[47:32]); ah = int'(p[31:16]);
        av = int'(p[15:0]);
        vis = s[31]; fl = s[30];
        x = int'(s[29:20]); y = int'(s[19:10]);
        dx = int'(h) - x;
        dy = int'(v) - y;
        ok = vis && rh != 0 && rv != 0 &&
             dx >= 0 && dx < ah && dy >= 0 && dy < av;
        kh = -1; kv = -1;
        for (int k = 0; k < 4; k++) begin
            if (kh < 0 && ah == rh * (1 << k)) kh = k;
            if (kv < 0 && av == rv * (1 << k)) kv = k;
        end
        if (kh < 0) begin kh = 0; if (dx >= rh) ok = 0; end
        if (kv < 0) begin kv = 0; if (dy >= rv) ok = 0; end
        if (!ok) return 17'd0;
        col = dx / (1 << kh);
        row = dy / (1 << kv);
        if (fl) col = rh - 1 - col;
        addr = (ap + row * rh + col) % 65536;
        if (addr < 0) addr += 65536;
        return {1'b1, addr[15:0]};
    endfunction

    task automatic drive(
        input logic [79:0] p, input logic [31:0] s,
        input logic [9:0] h, input logic [9:0] v
    );
        bus.pattern_info = p;
        bus.sprite_info  = s;
        bus.hcount       = h;
        bus.vcount       = v;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(pat(0, 64, 64, 64, 64), spr(1, 0, 100, 50), 10'd110, 10'd60);
        #2;
        n_cmp++;
        if ({bus.valid, bus.addr_output} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_init got=%h want=0",
                     {bus.valid, bus.addr_output});
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.valid, bus.addr_output} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_hold got=%h want=0",
                     {bus.valid, bus.addr_output});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.addr_output !== 16'd650) begin
            n_bad++;
            $display("FAIL reset_resume got=%b/%0d want=1/650",
                     bus.valid, bus.addr_output);
        end
    endtask

    task automatic test_directed;
        logic [79:0] p[11];
        logic [31:0] s[11];
        logic [9:0]  h[11];
        logic [9:0]  v[11];
        logic        ev[11];
        logic [15:0] ea[11];
        p[0] = pat(0, 64, 64, 64, 64);  s[0] = spr(1, 0, 100, 50);
        h[0] = 110; v[0] = 60;  ev[0] = 1; ea[0] = 650;
        p[1] = p[0];                    s[1] = spr(1, 1, 100, 50);
        h[1] = 110; v[1] = 60;  ev[1] = 1; ea[1] = 693;
        p[2] = p[0];                    s[2] = s[0];
        h[2] = 164; v[2] = 60;  ev[2] = 0; ea[2] = 0;
        p[3] = p[0];                    s[3] = s[0];
        h[3] = 163; v[3] = 113; ev[3] = 1; ea[3] = 4095;
        p[4] = p[0];                    s[4] = s[0];
        h[4] = 99;  v[4] = 60;  ev[4] = 0; ea[4] = 0;
        p[5] = p[0];                    s[5] = spr(0, 0, 100, 50);
        h[5] = 110; v[5] = 60;  ev[5] = 0; ea[5] = 0;
        p[6] = pat(16'h0800, 64, 64, 64, 64); s[6] = s[0];
        h[6] = 110; v[6] = 60;  ev[6] = 1; ea[6] = 16'h0A8A;
        p[7] = pat(0, 64, 64, 128, 128); s[7] = spr(1, 0, 0, 0);
        h[7] = 21;  v[7] = 9;   ev[7] = 1; ea[7] = 266;
        p[8] = pat(0, 64, 64, 100, 64);  s[8] = spr(1, 0, 0, 0);
        h[8] = 70;  v[8] = 0;   ev[8] = 0; ea[8] = 0;
        p[9] = p[8];                     s[9] = s[8];
        h[9] = 63;  v[9] = 0;   ev[9] = 1; ea[9] = 63;
        p[10] = p[0];                    s[10] = s[1];
        h[10] = 100; v[10] = 50; ev[10] = 1; ea[10] = 63;
        for (int i = 0; i < 11; i++) begin
            drive(p[i], s[i], h[i], v[i]);
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.valid !== ev[i] || bus.addr_output !== ea[i]) begin
                n_bad++;
                $display("FAIL directed_%0d got=%b/%0d want=%b/%0d",
                         i, bus.valid, bus.addr_output, ev[i], ea[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        drive(pat(0, 64, 64, 64, 64), spr(1, 0, 100, 50), 10'd110, 10'd60);
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.valid !== 1'b1) begin
            n_bad++;
            $display("FAIL async_pre got=%b want=1", bus.valid);
        end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.valid, bus.addr_output} !== 17'd0) begin
            n_bad++;
            $display("FAIL async_clear got=%h want=0",
                     {bus.valid, bus.addr_output});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.addr_output !== 16'd650) begin
            n_bad++;
            $display("FAIL async_resume got=%b/%0d want=1/650",
                     bus.valid, bus.addr_output);
        end
    endtask

    task automatic test_random;
        logic [79:0] p;
        logic [31:0] s;
        logic [9:0]  h, v;
        logic [16:0] exp;
        int rh, rv, ah, av, x, y;
        for (int i = 0; i < 400; i++) begin
            rh = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 80));
            rv = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 80));
            ah = (($urandom % 4) == 0) ? int'($urandom_range(0, 300))
                                       : rh << $urandom_range(0, 3);
            av = (($urandom % 4) == 0) ? int'($urandom_range(0, 300))
                                       : rv << $urandom_range(0, 3);
            x  = int'($urandom_range(0, 1023));
            y  = int'($urandom_range(0, 1023));
            p  = pat(int'($urandom_range(0, 65535)), rh, rv, ah, av);
            s  = spr(($urandom % 8) != 0, $urandom % 2, x, y);
            s[9:0] = 10'($urandom);
            h  = 10'(x + int'($urandom_range(0, ah + 8)) - 4);
            v  = 10'(y + int'($urandom_range(0, av + 8)) - 4);
            exp = model(p, s, h, v);
            drive(p, s, h, v);
            @(posedge clk);
            #1;
            n_cmp++;
            if ({bus.valid, bus.addr_output} !== exp) begin
                n_bad++;
                $display("FAIL random_%0d got=%b/%0d want=%b/%0d",
                         i, bus.valid, bus.addr_output,
                         exp[16], exp[15:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [79:0] p;
        logic [31:0] s;
        logic [16:0] exp;
        p = pat(16'h1234, 16, 8, 32, 16);
        s = spr(1, 1, 1000, 3);
        for (int c = 990; c < 1024; c++) begin
            exp = model(p, s, 10'(c), 10'(c - 980));
            drive(p, s, 10'(c), 10'(c - 980));
            @(posedge clk);
            #1;
            n_cmp++;
            if ({bus.valid, bus.addr_output} !== exp) begin
                n_bad++;
                $display("FAIL b2b_h%0d got=%b/%0d want=%b/%0d",
                         c, bus.valid, bus.addr_output,
                         exp[16], exp[15:0]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
